instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
// Writer end of the instruction fetch interface: accepts decoded instruction fields on a
// valid/ready stream, re-encodes them into the 8-bit ISA word (inverse of the fetch decoder),
// and stores them in a DEPTH-entry program RAM at consecutive pc values. The core fetches
// through rd_pc/rd_instr. Used to load test programs without editing the ROM case table.
// PARAMETERS
// DEPTH   128  program RAM entries; addresses 0..DEPTH-1
// PC_W    16   width of pc/address ports
// PORTS
// clk          in   1     clock, rising edge
// reset        in   1     synchronous, active-high
// start        in   1     1-cycle pulse: begin load at start_addr
// start_addr   in   PC_W  first pc to write
// in_valid     in   1     field beat valid
// in_ready     out  1     loader accepts beat
// in_opcode    in   4     opcode [7:4]
// in_ra        in   3     first source reg (decoder reg1_i)
// in_rd        in   3     dest reg (decoder reg_o)
// in_imm       in   3     immediate (decoder imm)
// in_imm_flag  in   1     imm flag (decoder imm_flag)
// in_last      in   1     final beat of program
// busy         out  1     state==LOAD
// done         out  1     state==DONE
// error        out  1     state==ERR
// err_code     out  2     00 none, 01 illegal encoding, 10 overflow, 11 start_addr range
// wr_count     out  PC_W  beats written since last start
// rd_pc        in   PC_W  fetch address
// rd_instr     out  8     combinational fetch data
// BEHAVIOUR
// - Reset: state IDLE; in_ready/busy/done/error=0, err_code=00, wr_count=0, wr_ptr=0;
//   all per-entry valid bits cleared. Reset mid-load abandons load; written data invalid.
// - FSM IDLE/LOAD/DONE/ERR. start in IDLE/DONE/ERR: start_addr<DEPTH -> LOAD,
//   wr_ptr=start_addr, wr_count=0, err_code=00; else -> ERR, code 11. start in LOAD ignored.
// - in_ready = (state==LOAD), combinational. Beat = in_valid & in_ready.
// - Encoding, format from opcode: C={0010,0100}, I={1001,1101}, X={1110,1111}, M=rest.
//   C: word={op,imm,flag}; legal iff rd=={2'b01,flag}.
//   I: word={op,ra,flag}; legal iff rd==ra.
//   M, op!=0101: word={op,ra[1:0],rd[1:0]}; legal iff ra[2]==0 & rd[2]==1.
//   M, op==0101 (MVB): word={op,rd[1:0],ra[1:0]}; legal iff ra[2]==1 & rd[2]==0.
//   X: word={op,imm,flag}; always legal.
// - Legal beat: RAM[wr_ptr]<=word, valid set, wr_ptr++, wr_count++ on that edge; visible
//   on rd_instr the next cycle. in_last on beat -> DONE.
// - Illegal beat: nothing written, -> ERR code 01 (in_last irrelevant).
// - Legal beat at wr_ptr==DEPTH-1 without in_last: written, then -> ERR code 10.
//   With in_last: written, -> DONE.
// - rd_instr: RAM[rd_pc] if rd_pc<DEPTH and valid, else 8'hE0 (HALT). Read-during-write
//   same address returns old content.
// - DONE/ERR hold until start or reset; RAM contents persist across starts.
// TESTING
// - start addr 0; beat op=4 imm=000 flag=0 rd=010 last=0 -> RAM[0]=8'b01000000, wr_count=1.
// - beat op=6 ra=010 rd=101 -> 8'b01101001; op=5 ra=100 rd=001 -> 8'b01010100;
//   op=D ra=rd=100 flag=1 last=1 -> 8'b11011001, done=1, wr_count=4.
// - op=7 ra=110 rd=101 -> error=1, err_code=01, target entry still reads 8'hE0.
// - start_addr=126, 3 legal beats no last -> 126,127 written, third rejected?: 2 written,
//   ERR code 10 after beat at 127; in_ready=0 afterwards.
// - start_addr=200 -> ERR code 11 next cycle; rd_pc=200 -> 8'hE0.
// - reset asserted mid-load after 2 beats -> IDLE, all outputs reset, rd_instr=8'hE0 everywhere.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction loader: re-encodes decoded instruction fields into 8-bit ISA words
// and writes them into a program RAM that the core fetches from combinationally.
module instr_loader #(
  parameter int DEPTH = 128,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [2:0]      in_ra,
  input  logic [2:0]      in_rd,
  input  logic [2:0]      in_imm,
  input  logic            in_imm_flag,
  input  logic            in_last,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code,
  output logic [PC_W-1:0] wr_count,
  input  logic [PC_W-1:0] rd_pc,
  output logic [7:0]      rd_instr
);

  localparam int              ADDR_W    = $clog2(DEPTH);
  localparam logic [PC_W-1:0] DEPTH_PC  = PC_W'(DEPTH);
  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);
  localparam logic [7:0]      HALT_WORD = 8'hE0;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   wr_ptr, wr_ptr_nxt, wr_count_nxt;
  logic [1:0]        err_code_nxt;
  logic              wr_en, beat, legal;
  logic [7:0]        word;
  logic [7:0]        mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  // Inverse of the fetch decoder: the opcode selects the field layout and legality rule.
  always_comb begin
    word  = {in_opcode, in_ra[1:0], in_rd[1:0]};
    legal = ~in_ra[2] & in_rd[2];
    case (in_opcode)
      4'b0010, 4'b0100: begin
        word  = {in_opcode, in_imm, in_imm_flag};
        legal = (in_rd == {2'b01, in_imm_flag});
      end
      4'b1001, 4'b1101: begin
        word  = {in_opcode, in_ra, in_imm_flag};
        legal = (in_rd == in_ra);
      end
      4'b1110, 4'b1111: begin
        word  = {in_opcode, in_imm, in_imm_flag};
        legal = 1'b1;
      end
      4'b0101: begin
        word  = {in_opcode, in_rd[1:0], in_ra[1:0]};
        legal = in_ra[2] & ~in_rd[2];
      end
      default: ;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign beat     = in_valid & in_ready;

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    wr_count_nxt = wr_count;
    err_code_nxt = err_code;
    wr_en        = 1'b0;
    case (state)
      LOAD: begin
        if (beat) begin
          if (legal) begin
            wr_en        = 1'b1;
            wr_ptr_nxt   = wr_ptr + 1'b1;
            wr_count_nxt = wr_count + 1'b1;
            if (in_last) begin
              state_nxt = DONE;
            end else if (wr_ptr == LAST_ADDR) begin
              state_nxt    = ERR;
              err_code_nxt = 2'b10;
            end
          end else begin
            state_nxt    = ERR;
            err_code_nxt = 2'b01;
          end
        end
      end
      default: begin
        if (start) begin
          if (start_addr < DEPTH_PC) begin
            state_nxt    = LOAD;
            wr_ptr_nxt   = start_addr;
            wr_count_nxt = '0;
            err_code_nxt = 2'b00;
          end else begin
            state_nxt    = ERR;
            err_code_nxt = 2'b11;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      wr_count <= '0;
      err_code <= 2'b00;
      vld      <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      wr_count <= wr_count_nxt;
      err_code <= err_code_nxt;
      if (wr_en) vld[wr_ptr[ADDR_W-1:0]] <= 1'b1;
    end
  end

  // Storage carries no reset; the valid bits alone decide what fetch sees.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr[ADDR_W-1:0]] <= word;
  end

  assign rd_instr = ((rd_pc < DEPTH_PC) && vld[rd_pc[ADDR_W-1:0]])
                    ? mem[rd_pc[ADDR_W-1:0]] : HALT_WORD;

endmodule
